sram_bank: RTL and testbench
============================

# sram_bank

Parametrised single-port synchronous SRAM bank, the successor to the fixed 8-bit `sram`. It adds a configurable data width with per-byte write enables, a configurable read-pipeline latency, and a request/ready handshake. An optional zero-fill sequencer clears the array after reset, and the bank refuses requests until the clear completes. It sits behind the core's load/store path as the general on-chip memory primitive.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 10: address width; `DEPTH` = 2**`ADDR_W` words. All addresses are in range.
- `READ_LAT`, 1: read latency in cycles, legal range 1..4.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the array after reset; 0 = no clear.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read; sampled with `cs`.
- `addr`  in  `ADDR_W`  word address.
- `wdata`  in  `DATA_W`  write data.
- `be`  in  `DATA_W`/8  byte-lane write enables; `be[i]` covers `wdata[8i+7:8i]`; ignored on reads.
- `ready`  out  1  bank accepts requests.
- `rdata`  out  `DATA_W`  read data; holds its value until the next `rvalid`.
- `rvalid`  out  1  one-cycle pulse marking `rdata` valid.

## Operation
- **States:** CLEAR and RUN.
- **Reset behaviour:**
  - `rst`=1 at an edge sets state to CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
  - The same edge sets the clear counter to 0, empties the read pipeline, and sets `rvalid`=0 and `rdata`=0.
  - `ready` = (state == RUN) && !`rst`, so `ready`=0 while `rst` is high.
- **CLEAR state:**
  - Each edge with `rst`=0 writes all-zeros to address = counter, then increments the counter.
  - At counter == `DEPTH`-1 the write happens and state moves to RUN.
  - `cs` is ignored throughout CLEAR; requests are dropped, not queued.
- **RUN state, request accept:** a request is accepted at an edge where `cs`=1 and `ready`=1. At most one request is accepted per cycle.
- **Accepted write:** each lane with `be[i]`=1 updates at that edge; lanes with `be[i]`=0 keep their old value. `be`=0 is a legal no-op.
- **Accepted read:**
  - The array is sampled at the acceptance edge and the value enters a `READ_LAT`-deep pipeline.
  - A read accepted the cycle after a write to the same address returns the new data.
- **Back-to-back operation:** consecutive reads produce consecutive `rvalid` pulses, returned in issue order.
- **Memory contents across reset:**
  - With `CLEAR_ON_RESET`=0, contents are retained across reset; they are X after power-up.
  - With `CLEAR_ON_RESET`=1, contents are zero once `ready` rises.
- **Reset mid-operation:**
  - Reset during CLEAR restarts the clear at address 0.
  - Reset with reads in flight discards them; no `rvalid` is produced for them.
  - A write accepted before reset is kept.

## Timing
- **Reset outputs:** `ready`=0, `rvalid`=0, `rdata`=0.
- **Clear duration:** with `CLEAR_ON_RESET`=1, `ready` rises after exactly `DEPTH` rising edges with `rst`=0, counted from the first such edge.
- **No clear:** with `CLEAR_ON_RESET`=0, `ready`=1 in the first cycle with `rst`=0.
- **Read latency:** for a read accepted at edge t, `rvalid`=1 and `rdata` is valid for the single cycle after edge t+`READ_LAT`-1.
- **Write latency:** a write takes effect at its acceptance edge; there is no write response.
- **Throughput:** one request per cycle sustained in RUN, independent of `READ_LAT`.

## Test plan
All scenarios use `DATA_W`=32, `ADDR_W`=4 (`DEPTH`=16), `READ_LAT`=2, `CLEAR_ON_RESET`=1.
- **Clear after reset:** hold `rst` for 2 cycles, then release. `ready` stays low for 16 cycles and rises on the 17th. Reads of addresses 0..15 all return 0x00000000.
- **Full write then read:** write 0xDEADBEEF to address 3 with `be`=4'b1111. Read address 3 accepted at edge t gives `rvalid`=1 after edge t+1, with `rdata`=0xDEADBEEF.
- **Byte enables:** over the address-3 data, write 0x11223344 with `be`=4'b0101. Reading address 3 returns 0xDE22BE44. A write with `be`=0 leaves the word unchanged.
- **Pipelining:**
  - Reads of addresses 1, 2, 3 on consecutive cycles, after writing 0xA1, 0xA2, 0xA3 there, give three consecutive `rvalid` cycles carrying 0xA1, 0xA2, 0xA3.
  - Writing 0x55 to address 5 and then reading address 5 the next cycle returns 0x55.
- **Reset mid-clear and mid-read:**
  - Assert `rst` on the 5th clear cycle. `ready` rises only after 16 full clear cycles following release.
  - Assert `rst` one cycle after a read is accepted. No `rvalid` is seen for that read, and `rdata`=0.
- **Requests during clear:** a write of 0xFFFFFFFF to address 7 with `cs`=1 during CLEAR is ignored; address 7 reads 0 after `ready` rises.

Source files
------------

// File: rtl/sram_bank.sv
// sram_bank: parametrised single-port synchronous SRAM bank.
// Features: per-byte write enables, a READ_LAT-deep read pipeline and a cs/ready handshake.
// An optional zero-fill sequencer clears the array after reset; requests are refused
// until the clear finishes.
module sram_bank #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LANES = DATA_W / 8;

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    // Elaboration-time sanity checks on the parameter set.
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("sram_bank: DATA_W must be a multiple of 8");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("sram_bank: READ_LAT must be in 1..4");
    end

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Stage READ_LAT-1 is the output register; earlier stages are internal delay.
    logic              pipe_vld_q  [READ_LAT];
    logic [DATA_W-1:0] pipe_data_q [READ_LAT];

    logic clearing;
    logic clr_last;
    logic accept;
    logic wr_accept;
    logic rd_accept;

    assign clearing  = (state_q == StClear);
    assign clr_last  = &clr_cnt_q;
    assign ready     = (state_q == StRun) && !rst;
    assign accept    = cs && ready;
    assign wr_accept = accept && wr;
    assign rd_accept = accept && !wr;

    // Next state for the clear sequencer: walk every address once, then open for requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clearing) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_last) begin
                state_d = StRun;
            end
        end
    end

    // Control state; reset restarts the clear from address 0 when clearing is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StRun;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array writes: zero-fill during clear, byte-lane merge for accepted writes. Not reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline: sample the array on accept, shift towards the output.
    // Data registers only load alongside a valid, so rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data_q[0] <= mem[addr];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    assign rvalid = pipe_vld_q[READ_LAT-1];
    assign rdata  = pipe_data_q[READ_LAT-1];

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: directed bench for sram_bank with a cycle-level reference model.
module tb_sram_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RL    = 2;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;

    int checks = 0;
    int errors = 0;

    sram_bank #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .READ_LAT(RL),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .wr(wr),
        .addr(addr),
        .wdata(wdata),
        .be(be),
        .ready(ready),
        .rdata(rdata),
        .rvalid(rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] m_mem [DEPTH];
    bit          m_run = 1'b0;
    int          m_clr = 0;
    int          cyc = 0;
    bit          started = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    // Advance the model on each rising edge, then compare just after it.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1'b1;
            m_run   = 1'b0;
            m_clr   = 0;
            rq.delete();
            m_rdata = '0;
        end else if (!m_run) begin
            m_mem[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) m_run = 1'b1;
        end else if (cs) begin
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_mem[addr][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                rq.push_back('{due: cyc + RL - 1, data: m_mem[addr]});
            end
        end
        m_rvalid = 1'b0;
        if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
            m_rvalid = 1'b1;
            m_rdata  = rq[0].data;
            void'(rq.pop_front());
        end
        #1;
        if (started) begin
            check32("model_ready", {31'b0, ready}, {31'b0, m_run && !rst});
            check32("model_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
            check32("model_rdata", rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic write_req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    // Read accepted at the next edge; exactly RL-1 edges later rvalid must be up.
    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        cs = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        check32({name, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        check32(name, rdata, exp);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        @(negedge clk);
        check32("reset_ready", {31'b0, ready}, 32'd0);
        check32("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check32("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Clear after reset, with a write attempt to address 7 during the clear.
        n = 0;
        while (!ready && n < 100) begin
            if (n < 3) begin
                cs = 1'b1; wr = 1'b1; addr = 4'd7; wdata = 32'hFFFF_FFFF; be = 4'hF;
            end else begin
                cs = 1'b0; wr = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        cs = 1'b0; wr = 1'b0;
        check32("clear_edges", n, 32'd16);
        for (int a = 0; a < 16; a++) read_check("clear_read", a[AW-1:0], 32'h0);

        // Full write then read.
        write_req(4'd3, 32'hDEAD_BEEF, 4'b1111);
        read_check("full_wr_rd", 4'd3, 32'hDEAD_BEEF);

        // Byte enables.
        write_req(4'd3, 32'h1122_3344, 4'b0101);
        read_check("be_0101", 4'd3, 32'hDE22_BE44);
        write_req(4'd3, 32'h0000_0000, 4'b0000);
        read_check("be_none", 4'd3, 32'hDE22_BE44);

        // Pipelined reads of 1, 2, 3.
        write_req(4'd1, 32'hA1, 4'hF);
        write_req(4'd2, 32'hA2, 4'hF);
        write_req(4'd3, 32'hA3, 4'hF);
        cs = 1'b1; wr = 1'b0; addr = 4'd1;
        @(negedge clk);
        addr = 4'd2;
        @(negedge clk);
        check32("pipe_v0", {31'b0, rvalid}, 32'd1);
        check32("pipe_d0", rdata, 32'hA1);
        addr = 4'd3;
        @(negedge clk);
        cs = 1'b0;
        check32("pipe_v1", {31'b0, rvalid}, 32'd1);
        check32("pipe_d1", rdata, 32'hA2);
        @(negedge clk);
        check32("pipe_v2", {31'b0, rvalid}, 32'd1);
        check32("pipe_d2", rdata, 32'hA3);
        @(negedge clk);
        check32("pipe_idle", {31'b0, rvalid}, 32'd0);
        check32("pipe_hold", rdata, 32'hA3);

        // Write then read of the same address on the next cycle.
        write_req(4'd5, 32'h55, 4'hF);
        read_check("wr_then_rd", 4'd5, 32'h55);

        // Reset one cycle after a read is accepted: the read is dropped.
        cs = 1'b1; wr = 1'b0; addr = 4'd3;
        @(negedge clk);
        cs = 1'b0; rst = 1'b1;
        @(negedge clk);
        check32("rstrd_rvalid", {31'b0, rvalid}, 32'd0);
        check32("rstrd_rdata", rdata, 32'h0);
        check32("rstrd_ready", {31'b0, ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check32("rstrd_rvalid2", {31'b0, rvalid}, 32'd0);
        wait_ready(n);
        check32("rstrd_clear_edges", n, 32'd15);

        // Reset on the 5th clear cycle restarts the full clear.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        check32("midclear_edges", n, 32'd16);
        read_check("after_clear", 4'd3, 32'h0);
        read_check("after_clear7", 4'd7, 32'h0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
